// File: rtl/det_event_reporter.sv
// det_event_reporter
//
// Counts the one-cycle match pulses from the serial sequence detector over a
// programmable window of clock cycles. At the end of each window the count is
// presented on a valid/ready report interface. While en stays high, windows
// run back-to-back with no gap cycle between them.
//
// Ports:
//   clk        system clock; all state updates on the rising edge
//   rst        asynchronous active-low reset
//   en         enables window counting; windows repeat while high
//   win_len    window length in cycles, sampled only at window start
//   y_in       match pulse; one count per high cycle inside a window
//   cnt_out    count of the last completed window (registered, saturating)
//   cnt_valid  cnt_out holds a report not yet accepted
//   cnt_ready  consumer accepts the report when cnt_valid && cnt_ready
//   lost       sticky flag: a report was overwritten before it was accepted
//   lost_clr   synchronous clear of lost (a coincident set wins)
//   busy       high while a window is in progress
module det_event_reporter #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIN_W-1:0] win_len,
  input  logic             y_in,
  output logic [CNT_W-1:0] cnt_out,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic             lost,
  input  logic             lost_clr,
  output logic             busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIN_W-1:0] WIN_ONE = {{(WIN_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIN_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
  logic             cnt_valid_q, cnt_valid_d;
  logic             lost_q, lost_d;

  logic [CNT_W-1:0] acc_sat;     // acc_q plus this cycle's pulse, clamped
  logic             final_vld;   // a window ends on this edge
  logic             accept;
  logic             start_ok;    // a new window may begin on this edge

  // Saturating increment: once the accumulator is all-ones it stays there.
  assign acc_sat  = (y_in && (acc_q != CNT_MAX)) ? (acc_q + CNT_ONE) : acc_q;
  assign start_ok = en && (win_len != '0);
  assign accept   = cnt_valid_q && cnt_ready;

  // Window FSM: next state, timer and accumulator.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    acc_d     = acc_q;
    final_vld = 1'b0;

    unique case (state_q)
      IDLE: begin
        // y_in is ignored here, including on the start cycle.
        if (start_ok) begin
          timer_d = win_len - WIN_ONE;
          acc_d   = '0;
          state_d = COUNT;
        end
      end

      COUNT: begin
        if (!en) begin
          // Abort: the partial count is discarded and no report is made.
          state_d = IDLE;
          acc_d   = '0;
          timer_d = '0;
        end else if (timer_q != '0) begin
          timer_d = timer_q - WIN_ONE;
          acc_d   = acc_sat;
        end else begin
          // Last window cycle: acc_sat is the final count for this window.
          final_vld = 1'b1;
          if (start_ok) begin
            // Reload immediately so the next window has no gap cycle.
            timer_d = win_len - WIN_ONE;
            acc_d   = '0;
          end else begin
            state_d = IDLE;
            acc_d   = '0;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Report stage: a new final always loads; an unaccepted old report is lost.
  always_comb begin
    cnt_out_d   = cnt_out_q;
    cnt_valid_d = cnt_valid_q;
    lost_d      = lost_q;

    if (final_vld) begin
      cnt_out_d   = acc_sat;
      cnt_valid_d = 1'b1;
    end else if (accept) begin
      cnt_valid_d = 1'b0;
    end

    // Setting has priority over a coincident lost_clr.
    if (final_vld && cnt_valid_q && !accept) begin
      lost_d = 1'b1;
    end else if (lost_clr) begin
      lost_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      acc_q       <= '0;
      cnt_out_q   <= '0;
      cnt_valid_q <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      acc_q       <= acc_d;
      cnt_out_q   <= cnt_out_d;
      cnt_valid_q <= cnt_valid_d;
      lost_q      <= lost_d;
    end
  end

  assign cnt_out   = cnt_out_q;
  assign cnt_valid = cnt_valid_q;
  assign lost      = lost_q;
  assign busy      = (state_q == COUNT);

endmodule

// File: tb/tb_det_event_reporter.sv
// tb_det_event_reporter
//
// Directed testbench for det_event_reporter. Inputs are changed 1 time unit
// after each rising edge and outputs are checked at the same point, so every
// check sees the state produced by the edge just taken.
module tb_det_event_reporter;

  localparam int CNT_W = 8;
  localparam int WIN_W = 16;

  logic             clk;
  logic             rst;
  logic             en;
  logic [WIN_W-1:0] win_len;
  logic             y_in;
  logic [CNT_W-1:0] cnt_out;
  logic             cnt_valid;
  logic             cnt_ready;
  logic             lost;
  logic             lost_clr;
  logic             busy;

  int tests_run = 0;
  int tests_failed = 0;

  det_event_reporter #(
    .CNT_W(CNT_W),
    .WIN_W(WIN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .win_len   (win_len),
    .y_in      (y_in),
    .cnt_out   (cnt_out),
    .cnt_valid (cnt_valid),
    .cnt_ready (cnt_ready),
    .lost      (lost),
    .lost_clr  (lost_clr),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one full window after the start edge; pattern bit c-1 is y_in in window
  // cycle c. ready_last drives cnt_ready only during the last window cycle and
  // clr_last drives lost_clr only then.
  task automatic run_window(input int len, input logic [31:0] pattern,
                            input logic ready_last, input logic clr_last);
    for (int c = 1; c <= len; c++) begin
      y_in      = pattern[c-1];
      cnt_ready = (c == len) ? ready_last : 1'b0;
      lost_clr  = (c == len) ? clr_last : 1'b0;
      tick();
    end
    y_in      = 1'b0;
    cnt_ready = 1'b0;
    lost_clr  = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    en        = 1'b0;
    win_len   = '0;
    y_in      = 1'b0;
    cnt_ready = 1'b0;
    lost_clr  = 1'b0;

    // Reset state
    #2;
    check("rst_cnt_out", 32'(cnt_out), 0);
    check("rst_valid", 32'(cnt_valid), 0);
    check("rst_lost", 32'(lost), 0);
    check("rst_busy", 32'(busy), 0);
    tick();
    rst = 1'b1;
    tick();

    // Reset mid-window: two pulses counted, then reset asserted asynchronously
    en = 1'b1; win_len = 16'd8;
    tick();
    check("mid_busy_before", 32'(busy), 1);
    y_in = 1'b1; tick();
    tick();
    y_in = 1'b0; tick();
    #2 rst = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_valid", 32'(cnt_valid), 0);
    check("mid_rst_cnt", 32'(cnt_out), 0);
    check("mid_rst_lost", 32'(lost), 0);
    en = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("mid_no_report", 32'(cnt_valid), 0);

    // Basic window: pulses in cycles 1, 4, 8 -> 3
    en = 1'b1; win_len = 16'd8;
    tick();
    check("basic_busy", 32'(busy), 1);
    run_window(8, 32'b1000_1001, 1'b0, 1'b0);
    check("basic_valid", 32'(cnt_valid), 1);
    check("basic_cnt", 32'(cnt_out), 3);
    en = 1'b0;
    tick();
    check("basic_abort_busy", 32'(busy), 0);
    tick(); tick();
    check("basic_held_valid", 32'(cnt_valid), 1);
    check("basic_held_cnt", 32'(cnt_out), 3);
    cnt_ready = 1'b1;
    tick();
    cnt_ready = 1'b0;
    check("basic_acc_valid", 32'(cnt_valid), 0);
    check("basic_acc_cnt", 32'(cnt_out), 3);

    // Saturation: 300 pulses in a 400-cycle window -> 255
    en = 1'b1; win_len = 16'd400;
    tick();
    for (int c = 1; c <= 400; c++) begin
      y_in = (c <= 300);
      tick();
    end
    y_in = 1'b0;
    check("sat_cnt", 32'(cnt_out), 255);
    check("sat_valid", 32'(cnt_valid), 1);
    check("sat_lost", 32'(lost), 0);
    en = 1'b0;
    tick();
    cnt_ready = 1'b1;
    tick();
    cnt_ready = 1'b0;
    check("sat_acc_valid", 32'(cnt_valid), 0);

    // Back-pressure: windows of 2 then 1 with no acceptance
    en = 1'b1; win_len = 16'd4;
    tick();
    run_window(4, 32'b0101, 1'b0, 1'b0);
    check("bp_w1_cnt", 32'(cnt_out), 2);
    check("bp_w1_lost", 32'(lost), 0);
    check("bp_w1_busy", 32'(busy), 1);
    run_window(4, 32'b0010, 1'b0, 1'b0);
    check("bp_w2_cnt", 32'(cnt_out), 1);
    check("bp_w2_lost", 32'(lost), 1);
    en = 1'b0; lost_clr = 1'b1;
    tick();
    lost_clr = 1'b0;
    check("bp_clr_lost", 32'(lost), 0);
    check("bp_clr_valid", 32'(cnt_valid), 1);
    // Set coincident with lost_clr: set wins
    en = 1'b1;
    tick();
    run_window(4, 32'b1111, 1'b0, 1'b1);
    check("bp_setclr_lost", 32'(lost), 1);
    check("bp_setclr_cnt", 32'(cnt_out), 4);
    en = 1'b0;
    tick();
    lost_clr = 1'b1;
    tick();
    lost_clr = 1'b0;
    check("bp_clr2_lost", 32'(lost), 0);

    // Simultaneous accept and new result
    en = 1'b1; win_len = 16'd4;
    tick();
    run_window(4, 32'b0100, 1'b1, 1'b0);
    check("sim_valid", 32'(cnt_valid), 1);
    check("sim_cnt", 32'(cnt_out), 1);
    check("sim_lost", 32'(lost), 0);
    en = 1'b0;
    tick();
    cnt_ready = 1'b1;
    tick();
    cnt_ready = 1'b0;
    check("sim_acc_valid", 32'(cnt_valid), 0);

    // Abort at window cycle 3
    en = 1'b1; win_len = 16'd4;
    tick();
    y_in = 1'b1; tick(); tick();
    en = 1'b0; tick();
    y_in = 1'b0;
    check("abort_busy", 32'(busy), 0);
    for (int i = 0; i < 6; i++) tick();
    check("abort_valid", 32'(cnt_valid), 0);
    check("abort_cnt", 32'(cnt_out), 1);

    // Zero length window stays idle
    en = 1'b1; win_len = 16'd0;
    tick(); tick(); tick();
    check("zero_busy", 32'(busy), 0);
    check("zero_valid", 32'(cnt_valid), 0);

    // win_len change mid-window has no effect on the running window
    win_len = 16'd3;
    tick();
    win_len = 16'd8;
    run_window(3, 32'b111, 1'b0, 1'b0);
    check("wl_valid", 32'(cnt_valid), 1);
    check("wl_cnt", 32'(cnt_out), 3);
    en = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
